// File: rtl/pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect
// Description : Fetch PC sequencer with branch-redirect flush, registered
//               predictor-update record and saturating branch counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect #(
    parameter int               GRLEN    = 32,
    parameter logic [GRLEN-1:0] RESET_PC = GRLEN'(32'h1C00_0000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bru_valid,
    input  logic             bru_cancel,
    input  logic [GRLEN-1:0] bru_target,
    input  logic             bru_taken,
    input  logic [GRLEN-1:0] bru_pc,
    input  logic [GRLEN-1:0] bru_link_pc,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [GRLEN-1:0] fetch_pc,
    output logic             pipe_flush,
    output logic             brupd_valid,
    output logic [GRLEN-1:0] brupd_pc,
    output logic [GRLEN-1:0] brupd_target,
    output logic             brupd_taken,
    output logic             brupd_mispred,
    output logic [31:0]      perf_br_cnt,
    output logic [31:0]      perf_mispred_cnt
);

    localparam logic [1:0]  c_ST_BOOT  = 2'd0;
    localparam logic [1:0]  c_ST_RUN   = 2'd1;
    localparam logic [1:0]  c_ST_FLUSH = 2'd2;
    localparam logic [31:0] c_CNT_MAX  = 32'hFFFF_FFFF;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [GRLEN-1:0] r_fetch_pc;
    logic [GRLEN-1:0] w_fetch_pc_nxt;
    logic             w_redirect;
    logic             r_brupd_valid;
    logic [GRLEN-1:0] r_brupd_pc;
    logic [GRLEN-1:0] r_brupd_target;
    logic             r_brupd_taken;
    logic             r_brupd_mispred;
    logic [31:0]      r_perf_br_cnt;
    logic [31:0]      r_perf_mispred_cnt;

    assign w_redirect = bru_valid & bru_cancel;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        case (r_state)
            c_ST_BOOT:  w_state_nxt = c_ST_RUN;
            c_ST_RUN: begin
                if (fetch_ready) begin
                    w_fetch_pc_nxt = r_fetch_pc + GRLEN'(4);
                end
            end
            c_ST_FLUSH: w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_BOOT;
        endcase
        // A redirect wins over sequential advance in every state, including FLUSH.
        if (w_redirect) begin
            w_state_nxt    = c_ST_FLUSH;
            w_fetch_pc_nxt = {bru_target[GRLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_BOOT;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_brupd_valid   <= 1'b0;
            r_brupd_pc      <= '0;
            r_brupd_target  <= '0;
            r_brupd_taken   <= 1'b0;
            r_brupd_mispred <= 1'b0;
        end else begin
            r_brupd_valid <= bru_valid;
            if (bru_valid) begin
                r_brupd_pc      <= bru_pc;
                r_brupd_target  <= bru_taken ? bru_target : bru_link_pc;
                r_brupd_taken   <= bru_taken;
                r_brupd_mispred <= bru_cancel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_br_cnt      <= '0;
            r_perf_mispred_cnt <= '0;
        end else begin
            if (bru_valid && (r_perf_br_cnt != c_CNT_MAX)) begin
                r_perf_br_cnt <= r_perf_br_cnt + 32'd1;
            end
            if (w_redirect && (r_perf_mispred_cnt != c_CNT_MAX)) begin
                r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
            end
        end
    end

    assign fetch_valid      = (r_state == c_ST_RUN);
    assign pipe_flush       = (r_state == c_ST_FLUSH);
    assign fetch_pc         = r_fetch_pc;
    assign brupd_valid      = r_brupd_valid;
    assign brupd_pc         = r_brupd_pc;
    assign brupd_target     = r_brupd_target;
    assign brupd_taken      = r_brupd_taken;
    assign brupd_mispred    = r_brupd_mispred;
    assign perf_br_cnt      = r_perf_br_cnt;
    assign perf_mispred_cnt = r_perf_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect
// Description : Directed and random checks of pc_redirect against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect;

    localparam int          GRLEN    = 32;
    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bru_valid = 1'b0;
    logic        bru_cancel = 1'b0;
    logic [31:0] bru_target = '0;
    logic        bru_taken = 1'b0;
    logic [31:0] bru_pc = '0;
    logic [31:0] bru_link_pc = '0;
    logic        fetch_ready = 1'b1;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pipe_flush;
    logic        brupd_valid;
    logic [31:0] brupd_pc;
    logic [31:0] brupd_target;
    logic        brupd_taken;
    logic        brupd_mispred;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mispred_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: "booting" and "flushing" flags plus the architectural values.
    bit        m_boot = 1'b1;
    bit        m_flush = 1'b0;
    bit [31:0] m_pc = RESET_PC;
    bit        m_upd_v = 1'b0;
    bit [31:0] m_upd_pc = '0;
    bit [31:0] m_upd_tgt = '0;
    bit        m_upd_tk = 1'b0;
    bit        m_upd_mp = 1'b0;
    longint    m_br = 0;
    longint    m_mp = 0;

    pc_redirect #(.GRLEN(GRLEN), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .bru_valid        (bru_valid),
        .bru_cancel       (bru_cancel),
        .bru_target       (bru_target),
        .bru_taken        (bru_taken),
        .bru_pc           (bru_pc),
        .bru_link_pc      (bru_link_pc),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .pipe_flush       (pipe_flush),
        .brupd_valid      (brupd_valid),
        .brupd_pc         (brupd_pc),
        .brupd_target     (brupd_target),
        .brupd_taken      (brupd_taken),
        .brupd_mispred    (brupd_mispred),
        .perf_br_cnt      (perf_br_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_boot = 1'b1; m_flush = 1'b0; m_pc = RESET_PC;
            m_upd_v = 1'b0; m_upd_pc = '0; m_upd_tgt = '0; m_upd_tk = 1'b0; m_upd_mp = 1'b0;
            m_br = 0; m_mp = 0;
        end else begin
            if (bru_valid && bru_cancel) begin
                m_boot = 1'b0; m_flush = 1'b1; m_pc = bru_target & ~32'd3;
            end else if (m_boot || m_flush) begin
                m_boot = 1'b0; m_flush = 1'b0;
            end else if (fetch_ready) begin
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
            m_upd_v = bru_valid;
            if (bru_valid) begin
                m_upd_pc = bru_pc;
                m_upd_tgt = bru_taken ? bru_target : bru_link_pc;
                m_upd_tk = bru_taken;
                m_upd_mp = bru_cancel;
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (bru_cancel && m_mp < 64'hFFFF_FFFF) m_mp++;
            end
        end
    endtask

    task automatic compare_all();
        chk("fetch_valid", fetch_valid, !m_boot && !m_flush);
        chk("fetch_pc", fetch_pc, m_pc);
        chk("pipe_flush", pipe_flush, m_flush);
        chk("brupd_valid", brupd_valid, m_upd_v);
        chk("brupd_pc", brupd_pc, m_upd_pc);
        chk("brupd_target", brupd_target, m_upd_tgt);
        chk("brupd_taken", brupd_taken, m_upd_tk);
        chk("brupd_mispred", brupd_mispred, m_upd_mp);
        chk("perf_br_cnt", perf_br_cnt, m_br);
        chk("perf_mispred_cnt", perf_mispred_cnt, m_mp);
    endtask

    // Inputs are set 1 time unit after an edge; the model consumes them at the next edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_bru();
        bru_valid = 1'b0; bru_cancel = 1'b0; bru_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle_bru();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bru_valid = 1'b1; bru_cancel = 1'b1; bru_taken = 1'b1; bru_target = tgt;
        bru_pc = $urandom; bru_link_pc = $urandom;
    endtask

    initial begin
        // Release from reset and sequential fetch
        fetch_ready = 1'b1;
        do_reset();
        chk("boot_fetch_valid", fetch_valid, 1'b0);
        chk("reset_br_cnt", perf_br_cnt, 32'd0);
        cycle(); chk("seq0", fetch_pc, 32'h1C00_0000); chk("seq0_valid", fetch_valid, 1'b1);
        cycle(); chk("seq1", fetch_pc, 32'h1C00_0004);
        cycle(); chk("seq2", fetch_pc, 32'h1C00_0008);
        cycle(); cycle();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_pc", fetch_pc, 32'h1C00_0010);
            chk("stall_valid", fetch_valid, 1'b1);
        end
        fetch_ready = 1'b1;

        // Single redirect, misaligned target
        do_reset(); cycle();
        redirect_to(32'h1C00_0203);
        cycle(); idle_bru();
        chk("redir_flush", pipe_flush, 1'b1);
        chk("redir_fv", fetch_valid, 1'b0);
        cycle();
        chk("redir_fv2", fetch_valid, 1'b1);
        chk("redir_pc", fetch_pc, 32'h1C00_0200);
        chk("redir_mp", perf_mispred_cnt, 32'd1);

        // Back-to-back redirects
        do_reset(); cycle(); cycle();
        redirect_to(32'h100); cycle();
        chk("b2b_flush1", pipe_flush, 1'b1);
        redirect_to(32'h200); cycle(); idle_bru();
        chk("b2b_flush2", pipe_flush, 1'b1);
        cycle();
        chk("b2b_pc", fetch_pc, 32'h200);
        chk("b2b_fv", fetch_valid, 1'b1);
        chk("b2b_mp", perf_mispred_cnt, 32'd2);

        // Correctly predicted not-taken branch
        do_reset(); cycle();
        bru_valid = 1'b1; bru_cancel = 1'b0; bru_taken = 1'b0;
        bru_pc = 32'h40; bru_link_pc = 32'h44; bru_target = 32'h999;
        cycle(); idle_bru();
        chk("nt_upd_valid", brupd_valid, 1'b1);
        chk("nt_upd_target", brupd_target, 32'h44);
        chk("nt_upd_mispred", brupd_mispred, 1'b0);
        chk("nt_flush", pipe_flush, 1'b0);
        chk("nt_br_cnt", perf_br_cnt, 32'd1);
        cycle();
        chk("nt_upd_drop", brupd_valid, 1'b0);

        // Reset in the middle of a flush, with a competing redirect
        redirect_to(32'h0000_8000); cycle();
        reset = 1'b1; redirect_to(32'h0000_9000); cycle();
        reset = 1'b0; idle_bru(); cycle();
        chk("rst_flush_pc", fetch_pc, RESET_PC);
        chk("rst_flush_fv", fetch_valid, 1'b1);

        // Counter saturation and PC wrap
        @(negedge clk);
        force dut.r_perf_br_cnt = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.r_perf_br_cnt;
        m_br = 64'hFFFF_FFFE;
        m_pc = (fetch_ready && !m_boot && !m_flush) ? m_pc + 32'd4 : m_pc;
        compare_all();
        for (int i = 0; i < 3; i++) begin
            bru_valid = 1'b1; bru_cancel = 1'b0; bru_taken = 1'b0;
            bru_pc = $urandom; bru_link_pc = $urandom;
            cycle();
        end
        idle_bru();
        chk("sat_br_cnt", perf_br_cnt, 32'hFFFF_FFFF);
        redirect_to(32'hFFFF_FFFE); cycle(); idle_bru();
        cycle(); chk("wrap_pre", fetch_pc, 32'hFFFF_FFFC);
        cycle(); chk("wrap_post", fetch_pc, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            reset       = ($urandom_range(0, 99) < 2);
            bru_valid   = ($urandom_range(0, 99) < 35);
            bru_cancel  = ($urandom_range(0, 1) == 1);
            bru_taken   = ($urandom_range(0, 1) == 1);
            bru_target  = $urandom;
            bru_pc      = $urandom;
            bru_link_pc = $urandom;
            fetch_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
